avr_mem_arbiter: RTL
====================

# avr_mem_arbiter

Shares one synchronous single-port 16-bit memory between the AVR fetch unit (instruction reads) and the CPU data port (loads and stores). It sits between `avr_fetch` / `avr_cpu` and the memory macro and grants at most one access per cycle. Data accesses have priority, and a burst limit guarantees fetch forward progress. Read responses are routed back to their owner. In-flight fetch responses can be flushed after a PC redirect.

## Interface
Parameters:
- AW, 16, address width for all address ports
- MAX_D_BURST, 3, maximum number of consecutive data grants while a fetch waits; legal range 1..15

Ports:
- CLK  input  1  clock; all state updates on the rising edge
- RST_N  input  1  reset, asynchronous, active-low
- f_req  input  1  fetch read request
- f_addr  input  AW  fetch word address
- f_flush  input  1  discard all outstanding fetch responses (branch/jump taken)
- f_gnt  output  1  fetch request accepted this cycle (combinational)
- f_rvalid  output  1  fetch read data valid
- f_rdata  output  16  fetch read data
- d_req  input  1  data access request
- d_we  input  1  1 = write, 0 = read
- d_addr  input  AW  data address
- d_wdata  input  16  write data
- d_gnt  output  1  data request accepted this cycle (combinational)
- d_rvalid  output  1  data read data valid
- d_rdata  output  16  data read data
- mem_en  output  1  memory access enable (registered)
- mem_we  output  1  memory write enable (registered)
- mem_addr  output  AW  memory address (registered)
- mem_wdata  output  16  memory write data (registered)
- mem_rdata  input  16  memory read data, valid the cycle after mem_en & ~mem_we
- f_stall  output  1  f_req & ~f_gnt; used by the CPU as pc_select hold

## Operation
- Arbitration in cycle N is combinational from f_req, d_req and burst counter `cnt`. At most one of f_gnt / d_gnt is high.
  - Only d_req: d_gnt=1.
  - Only f_req: f_gnt=1.
  - Both, with cnt < MAX_D_BURST: d_gnt=1.
  - Both, with cnt == MAX_D_BURST: f_gnt=1.
- Counter `cnt`:
  - Increments (saturating at MAX_D_BURST) on each d_gnt while f_req=1.
  - Clears to 0 on any f_gnt, or any cycle with f_req=0.
- Issue stage, registered at the end of cycle N: mem_en = f_gnt|d_gnt; mem_we = d_gnt & d_we; mem_addr/mem_wdata come from the granted requester. mem_wdata=0 for reads.
  - Tag register `iss_own` ∈ {NONE, F, D} records the owner of a read. Writes record NONE.
- Response stage, registered at the end of cycle N+1: `rsp_own` <= iss_own.
  - In cycle N+2: f_rvalid = (rsp_own==F); d_rvalid = (rsp_own==D).
  - f_rdata and d_rdata both equal mem_rdata, passed through combinationally; rdata is meaningful only while its rvalid is high.
- Flush: when f_flush=1 in any cycle, every F tag in iss_own and rsp_own is changed to NONE at the next edge, and f_rvalid is forced to 0 in that same cycle.
  - A fetch granted in the same cycle as f_flush is accepted (new PC target) and is not flushed.
  - D tags are never affected by flush.
- Writes produce no response. Addresses are not decoded; AW bits pass through unchanged.

## Timing
- Reset (RST_N low, asynchronous): mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, iss_own=rsp_own=NONE, cnt=0, f_rvalid=d_rvalid=0. f_gnt/d_gnt still follow the combinational arbitration; the requesters are held in reset by the same RST_N.
- Reset asserted mid-operation drops all outstanding responses: no rvalid is produced for accesses granted before reset.
- Read latency: grant in cycle N -> mem_en in N+1 -> rvalid in N+2. Throughput is one access per cycle and back-to-back grants are allowed.
- Write: grant in N -> mem_en=mem_we=1 in N+1. A read of the same address granted in N+1 returns the new data.
- Requesters hold req/addr/data stable until they sample gnt=1; the arbiter has no request buffering.
- Starvation bound: with both requesting continuously, the pattern is MAX_D_BURST data grants then 1 fetch grant, repeating.

## Test plan
- Fetch only: f_req=1, f_addr=0x0000,0x0001,0x0002 on consecutive cycles; memory holds 0xE0A5 at 0x0000 -> f_gnt=1 every cycle, f_rvalid=1 in cycles 3,4,5, first f_rdata=0xE0A5, f_stall=0.
- Contention, MAX_D_BURST=3: f_req and d_req both held high for 8 cycles -> grant sequence D,D,D,F,D,D,D,F; f_stall high on the D cycles.
- Write then read: d_we=1, d_addr=0x0040, d_wdata=0x1234 in cycle 1, then d_we=0, d_addr=0x0040 in cycle 2 -> mem_we=1 in cycle 2; d_rvalid=1 with d_rdata=0x1234 in cycle 4; f_rvalid stays 0.
- Flush: fetches to 0x0010 and 0x0011 granted in cycles 1 and 2; f_flush=1 in cycle 3 with a fetch of 0x0100 granted -> no f_rvalid in cycles 3 or 4; f_rvalid=1 in cycle 5 carrying the 0x0100 word.
- Flush with a mixed pipeline: data read in cycle 1, fetch in cycle 2, f_flush in cycle 3 -> d_rvalid=1 in cycle 3; fetch response suppressed.
- Reset mid-stream: RST_N driven low asynchronously between edges with two reads in flight -> mem_en, f_rvalid and d_rvalid go 0 immediately and stay 0 after release until a new grant.

Source files
------------

// File: rtl/avr_mem_arbiter.sv
// avr_mem_arbiter: shares one synchronous single-port 16-bit memory between
// the AVR fetch unit and the CPU data port. Data accesses win, bounded by a
// burst limit so fetch always makes progress. Read responses are tagged with
// their owner and routed back two cycles after the grant; outstanding fetch
// responses can be flushed after a PC redirect.
module avr_mem_arbiter #(
    parameter int AW          = 16,
    parameter int MAX_D_BURST = 3
) (
    input  logic          CLK,
    input  logic          RST_N,
    // fetch port
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    input  logic          f_flush,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [15:0]   f_rdata,
    // data port
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [15:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [15:0]   d_rdata,
    // memory macro
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    input  logic [15:0]   mem_rdata,
    // pc_select hold for the CPU
    output logic          f_stall
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_F    = 2'd1,
        OWN_D    = 2'd2
    } own_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_D_BURST);

    logic [3:0] cnt;
    own_t       iss_own;
    own_t       rsp_own;

    // Grant selection: data wins unless a fetch has waited through a full burst.
    always_comb begin
        d_gnt = d_req & (~f_req | (cnt < MAX_CNT));
        f_gnt = f_req & ~d_gnt;
    end

    assign f_stall = f_req & ~f_gnt;

    // Burst counter: counts data grants taken while a fetch is waiting.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (!f_req || f_gnt) begin
            cnt <= '0;
        end else if (d_gnt && (cnt < MAX_CNT)) begin
            cnt <= cnt + 4'd1;
        end
    end

    // Issue stage: register the granted access toward the memory macro and tag its owner.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            iss_own   <= OWN_NONE;
        end else begin
            mem_en    <= f_gnt | d_gnt;
            mem_we    <= d_gnt & d_we;
            mem_wdata <= (d_gnt && d_we) ? d_wdata : 16'h0000;
            if (f_gnt) begin
                mem_addr <= f_addr;
            end else if (d_gnt) begin
                mem_addr <= d_addr;
            end
            // A fetch granted alongside a flush is the new PC target and is kept.
            if (f_gnt) begin
                iss_own <= OWN_F;
            end else if (d_gnt && !d_we) begin
                iss_own <= OWN_D;
            end else begin
                iss_own <= OWN_NONE;
            end
        end
    end

    // Response stage: follow the issued tag by one cycle, dropping fetch tags on flush.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rsp_own <= OWN_NONE;
        end else if (f_flush && (iss_own == OWN_F)) begin
            rsp_own <= OWN_NONE;
        end else begin
            rsp_own <= iss_own;
        end
    end

    // Response routing: memory data is shared, only the valids distinguish the owner.
    always_comb begin
        f_rvalid = (rsp_own == OWN_F) & ~f_flush;
        d_rvalid = (rsp_own == OWN_D);
        f_rdata  = mem_rdata;
        d_rdata  = mem_rdata;
    end

endmodule
